// File: rtl/channel_fifo_pkg.sv
// Shared channel package: width helpers for the
// Channel interface and the channel FIFO.
package channel_fifo_pkg;

  // Pointer width: enough bits to index Depth entries.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width: enough bits to hold 0..Depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/channel_fifo_if.sv
// Channel: data d, valid v, acknowledge a.
// master drives d/v and sees a; slave the reverse.
interface Channel #(
  parameter int N = 1
);
  logic [N-1:0] d;
  logic         v;
  logic         a;

  modport master (
    output d,
    output v,
    input  a
  );

  modport slave (
    input  d,
    input  v,
    output a
  );
endinterface

// File: rtl/channel_fifo_ptr.sv
// Wrapping FIFO pointer: advances by one on en_i.
// Ports: clk, reset (sync, active-high), en_i, ptr_o.
module channel_fifo_ptr
  import channel_fifo_pkg::*;
#(
  parameter  int Depth = 4,
  localparam int PW    = ptr_w(Depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      if (ptr_q == PW'(Depth - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/channel_fifo.sv
// Registered-output channel FIFO, no bypass.
// Ports: clk, reset, in (slave), out (master), count.
module channel_fifo
  import channel_fifo_pkg::*;
#(
  parameter  int N     = 1,
  parameter  int Depth = 4,
  localparam int PW    = ptr_w(Depth),
  localparam int CW    = cnt_w(Depth)
) (
  input  logic          clk,
  input  logic          reset,
  Channel.slave         in,
  Channel.master        out,
  output logic [CW-1:0] count
);

  logic [N-1:0]  mem_q [Depth];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake outputs come from count only, so
  // neither side sees a combinational path.
  assign in.a  = (count_q != CW'(Depth));
  assign out.v = (count_q != '0);
  assign out.d = mem_q[rd_ptr];

  assign push = in.v & in.a;
  assign pop  = out.v & out.a;

  channel_fifo_ptr #(
    .Depth (Depth)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (push),
    .ptr_o (wr_ptr)
  );

  channel_fifo_ptr #(
    .Depth (Depth)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (pop),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; a push in the
  // reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr] <= in.d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_channel_fifo.sv
// Directed and randomized bench for channel_fifo
// (N=8, Depth=4) with a queue model.
module tb_channel_fifo;

  logic       clk;
  logic       reset;
  logic [2:0] cnt;

  Channel #(.N(8)) in_ch ();
  Channel #(.N(8)) out_ch ();

  channel_fifo #(
    .N     (8),
    .Depth (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_ch),
    .out   (out_ch),
    .count (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_chk;
  int         n_fail;
  logic [7:0] src_q [$];
  logic [7:0] got_q [$];
  logic [7:0] mdl_q [$];
  logic [7:0] exp_q [$];
  int         gs;
  int         gk;
  bit         rnd;
  bit         snk_en;
  bit         chk_en;
  bit         fi;
  bit         fo;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drv(input bit f_in,
                     input bit f_out);
    if (f_in) gs = rnd ? int'($urandom_range(0, 5)) : 0;
    if (gs > 0) begin
      in_ch.v = 1'b0;
      gs--;
    end else begin
      in_ch.v = (src_q.size() != 0);
    end
    in_ch.d = (src_q.size() != 0) ? src_q[0] : 8'h00;
    if (f_out) gk = rnd ? int'($urandom_range(0, 5)) : 0;
    if (gk > 0) begin
      out_ch.a = 1'b0;
      gk--;
    end else begin
      out_ch.a = snk_en;
    end
  endtask

  task automatic step(output bit f_in,
                      output bit f_out);
    logic [7:0] di;
    logic [7:0] dq;
    @(negedge clk);
    f_in  = in_ch.v && in_ch.a;
    f_out = out_ch.v && out_ch.a;
    di = in_ch.d;
    dq = out_ch.d;
    if (chk_en) begin
      check("count", 32'(cnt), 32'(mdl_q.size()));
      check("cnt_le_depth", 32'(cnt <= 3'd4), 32'd1);
      check("in_a", 32'(in_ch.a),
            32'(mdl_q.size() != 4));
      check("out_v", 32'(out_ch.v),
            32'(mdl_q.size() != 0));
      if (mdl_q.size() != 0)
        check("out_d", 32'(dq), 32'(mdl_q[0]));
    end
    @(posedge clk);
    #1;
    if (reset) begin
      f_in  = 1'b0;
      f_out = 1'b0;
      mdl_q.delete();
      src_q.delete();
    end else begin
      if (f_out) begin
        got_q.push_back(dq);
        void'(mdl_q.pop_front());
      end
      if (f_in) begin
        mdl_q.push_back(di);
        void'(src_q.pop_front());
      end
    end
    drv(f_in, f_out);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(fi, fo);
    reset = 1'b0;
    got_q.delete();
  endtask

  initial begin
    bit         acc_exp [5];
    int         cnt_exp [6];
    logic [7:0] drain_exp [6];
    int         cyc;
    acc_exp   = '{1, 1, 1, 1, 0};
    cnt_exp   = '{3, 3, 3, 2, 1, 0};
    drain_exp = '{8'h11, 8'h22, 8'h33,
                  8'h44, 8'h55, 8'h66};
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    in_ch.v = 1'b0;
    in_ch.d = 8'h00;
    out_ch.a = 1'b0;
    rnd    = 1'b0;
    snk_en = 1'b0;
    chk_en = 1'b0;
    gs = 0;
    gk = 0;
    step(fi, fo);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      check("idle_v", 32'(out_ch.v), 32'd0);
      check("idle_a", 32'(in_ch.a), 32'd1);
      check("idle_cnt", 32'(cnt), 32'd0);
      step(fi, fo);
    end

    // Fill to full, fifth word held
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drv(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(fi, fo);
      check("push_acc", 32'(fi), 32'(acc_exp[i]));
    end
    check("full_cnt", 32'(cnt), 32'd4);
    check("full_a", 32'(in_ch.a), 32'd0);
    check("full_d", 32'(out_ch.d), 32'h11);
    step(fi, fo);
    check("full_hold_cnt", 32'(cnt), 32'd4);
    check("full_hold_d", 32'(out_ch.d), 32'h11);

    // Drain from full with 0x55,0x66 following
    src_q.push_back(8'h66);
    snk_en = 1'b1;
    got_q.delete();
    drv(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(fi, fo);
      check("drain_pop", 32'(fo), 32'd1);
      check("drain_cnt", 32'(cnt), 32'(cnt_exp[i]));
    end
    check("drain_n", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < got_q.size() && i < 6; i++)
      check("drain_ord", 32'(got_q[i]),
            32'(drain_exp[i]));
    check("drain_v", 32'(out_ch.v), 32'd0);
    check("drain_a", 32'(in_ch.a), 32'd1);

    // Streaming 0..99 after a 1-word prefill
    snk_en = 1'b0;
    do_reset();
    for (int i = 0; i < 100; i++)
      src_q.push_back(8'(i));
    drv(1'b0, 1'b0);
    step(fi, fo);
    check("pre_cnt", 32'(cnt), 32'd1);
    snk_en = 1'b1;
    drv(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(fi, fo);
      check("tput", 32'(fo), 32'd1);
    end
    check("seq_n", 32'(got_q.size()), 32'd100);
    for (int i = 0; i < got_q.size() && i < 100; i++)
      check("seq", 32'(got_q[i]), 32'(i));

    // Reset with three words stored
    snk_en = 1'b0;
    do_reset();
    src_q = '{8'h01, 8'h02, 8'h03};
    drv(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(fi, fo);
    check("pre_rst_cnt", 32'(cnt), 32'd3);
    reset = 1'b1;
    src_q.push_back(8'h77);
    snk_en = 1'b1;
    drv(1'b0, 1'b0);
    step(fi, fo);
    reset = 1'b0;
    got_q.delete();
    check("rst_v", 32'(out_ch.v), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_a", 32'(in_ch.a), 32'd1);
    src_q = '{8'hA5, 8'hB6};
    drv(1'b0, 1'b0);
    cyc = 0;
    while (got_q.size() < 2 && cyc < 20) begin
      step(fi, fo);
      cyc++;
    end
    check("rst_n", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("rst_first", 32'(got_q[0]), 32'hA5);
      check("rst_second", 32'(got_q[1]), 32'hB6);
    end

    // Random gaps on both sides, 1000 words
    snk_en = 1'b0;
    do_reset();
    rnd    = 1'b1;
    snk_en = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 1000; i++)
      exp_q.push_back(8'($urandom_range(0, 255)));
    src_q = exp_q;
    drv(1'b0, 1'b0);
    cyc = 0;
    while (got_q.size() < 1000 && cyc < 20000) begin
      step(fi, fo);
      cyc++;
    end
    check("rnd_n", 32'(got_q.size()), 32'd1000);
    for (int i = 0; i < got_q.size() && i < 1000; i++)
      check("rnd_ord", 32'(got_q[i]), 32'(exp_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_fifo.md
CHANNEL_FIFO -- requirements
Module: channel_fifo

Interface
REQ-001 Parameter N, default 1, data width in bits of both channels.
REQ-002 Parameter Depth, default 4, number of storage entries; SHALL be a power of 2 and at least 2.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 in  Channel #(N) consumer side  N+2  in.d data, in.v valid (driven by upstream), in.a acknowledge (driven here).
REQ-006 out  Channel #(N) producer side  N+2  out.d data, out.v valid (driven here), out.a acknowledge (driven by downstream).
REQ-007 count  output  $clog2(Depth+1)  number of occupied entries.

Function
REQ-008 A transfer on either channel SHALL occur exactly on a posedge clk where v==1 and a==1.
REQ-009 in.a SHALL be a combinational function of registered state only: in.a = (count != Depth).
REQ-010 out.v SHALL be registered-state only: out.v = (count != 0), and SHALL NOT depend combinationally on in.v or out.a.
REQ-011 out.d SHALL equal the oldest stored word whenever out.v==1; out.d is don't-care when out.v==0.
REQ-012 Push: on an in transfer, in.d SHALL be written at the write pointer, and the write pointer SHALL advance by 1 modulo Depth.
REQ-013 Pop: on an out transfer, the read pointer SHALL advance by 1 modulo Depth.
REQ-014 count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push and pop or on neither.
REQ-015 Latency: a word pushed at posedge k into an empty FIFO SHALL present out.v==1 after posedge k (first pop possible at posedge k+1); there is no combinational bypass.
REQ-016 Full (count==Depth): in.a==0, so no push occurs even if a pop occurs in the same cycle.
REQ-017 Empty (count==0): out.v==0, so no pop occurs.
REQ-018 Words SHALL leave in the exact order they entered, with no loss or duplication, across pointer wrap-around.
REQ-019 Full throughput: with count strictly between 0 and Depth and both sides continuously valid/acking, one push and one pop SHALL occur every cycle.
REQ-020 out.v, once asserted, SHALL stay asserted with out.d stable until the pop or until reset.

Reset
REQ-021 When reset==1 at posedge: read pointer=0, write pointer=0, count=0; hence out.v=0 and in.a=1 from the following cycle.
REQ-022 Reset mid-operation SHALL discard all stored words; transfers presented in the reset cycle SHALL be ignored.
REQ-023 Storage array contents need not be reset.

Structure
REQ-024 Pointer width and count width derivations ($clog2 helpers) SHALL live in the shared channel package alongside the Channel interface definitions.
REQ-025 Pointer increment-with-wrap SHALL be a sub-module channel_fifo_ptr (enable in, pointer out, synchronous reset), instantiated once for read and once for write.
REQ-026 Storage SHALL be a plain register array indexed by the pointers; no vendor RAM primitives.

Verification
REQ-027 Reset, then idle: out.v==0, in.a==1, count==0 for 5 cycles.
REQ-028 N=8, Depth=4, out.a held 0, push 0x11,0x22,0x33,0x44,0x55: first four accepted, count==4, in.a==0, 0x55 held by source.
REQ-029 From the full state, out.a=1 for 6 cycles with source pushing 0x55,0x66: popped order 0x11,0x22,0x33,0x44,0x55,0x66; pointers wrap; count ends 0.
REQ-030 Continuous source and sink for 100 words 0..99 after a 1-word prefill: one pop per cycle, output sequence 0..99 in order.
REQ-031 Assert reset with count==3: next cycle out.v==0, count==0; the next pushed word 0xA5 is the first popped.
REQ-032 Randomized source (0-5 cycle gaps) and randomized sink (0-5 cycle ack delays), 1000 words: scoreboard order match, count never exceeds Depth, no push when full, no pop when empty.
